dmi_initiator: RTL and testbench

DMI_INITIATOR -- requirements
Module: dmi_initiator

---
 rtl/dm_pkg.sv | 43 ++++
 rtl/dmi_initiator.sv | 127 ++++++++++++
 tb/tb_dmi_initiator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug-module transport types shared by the DTM-side DMI initiator and its neighbours.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'h0,
    DTM_ERR     = 2'h2,
    DTM_BUSY    = 2'h3
  } dtm_op_status_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } dmi_state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    dtm_op_e     op;
  } dmi_scan_t;

  localparam int DmiScanWidth = 41;

endpackage

// File: rtl/dmi_initiator.sv
// Turns JTAG dmi scan updates into DMI request/response transactions and
// keeps the sticky dmistat error reported back through the capture word.
module dmi_initiator
  import dm::*;
#(
  parameter int DmiAddrWidth = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    update_i,
  input  logic [DmiScanWidth-1:0] scan_i,
  input  logic                    capture_i,
  output logic [DmiScanWidth-1:0] capture_o,
  input  logic                    dmireset_i,
  input  logic                    dmihardreset_i,
  output logic                    dmi_req_valid_o,
  output dmi_req_t                dmi_req_o,
  input  logic                    dmi_req_ready_i,
  input  logic                    dmi_resp_valid_i,
  input  dmi_resp_t               dmi_resp_i,
  output logic                    dmi_resp_ready_o,
  output dtm_op_status_e          dmistat_o,
  output dmi_state_e              state_o
);

  // Handshakes: a request transfers on a cycle where dmi_req_valid_o and
  // dmi_req_ready_i are both high; valid and the payload stay stable until
  // then (only a hard reset may withdraw it). A response transfers on a cycle
  // where dmi_resp_valid_i and dmi_resp_ready_o are both high.

  dmi_state_e            state_q;
  logic [DmiAddrWidth-1:0] addr_q;
  logic [31:0]           data_q;
  dtm_op_status_e        error_q;
  dtm_op_status_e        error_d;
  logic                  req_valid_q;
  logic                  resp_ready_q;
  dmi_scan_t             scan;
  logic                  in_wait;

  assign scan    = scan_i;
  assign in_wait = (state_q == WaitRead) || (state_q == WaitWrite);

  // Sticky error: only the first fault after a clear is recorded; dmireset wins.
  always_comb begin
    error_d = error_q;
    if (error_q == DTM_SUCCESS) begin
      if ((update_i || capture_i) && (state_q != Idle)) error_d = DTM_BUSY;
      if (in_wait && dmi_resp_valid_i && (dmi_resp_i.resp == DTM_ERR)) error_d = DTM_ERR;
    end
    if (dmireset_i) error_d = DTM_SUCCESS;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      addr_q       <= '0;
      data_q       <= '0;
      error_q      <= DTM_SUCCESS;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else if (dmihardreset_i) begin
      state_q      <= Idle;
      addr_q       <= '0;
      data_q       <= '0;
      error_q      <= DTM_SUCCESS;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      error_q <= error_d;
      unique case (state_q)
        Idle: begin
          if (update_i && (error_q == DTM_SUCCESS)) begin
            if (scan.op == DTM_READ) begin
              addr_q      <= scan.addr;
              state_q     <= Read;
              req_valid_q <= 1'b1;
            end else if (scan.op == DTM_WRITE) begin
              addr_q      <= scan.addr;
              data_q      <= scan.data;
              state_q     <= Write;
              req_valid_q <= 1'b1;
            end
          end
        end
        Read, Write: begin
          if (dmi_req_ready_i) begin
            state_q      <= (state_q == Read) ? WaitRead : WaitWrite;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        WaitRead, WaitWrite: begin
          if (dmi_resp_valid_i) begin
            if (state_q == WaitRead) data_q <= dmi_resp_i.data;
            state_q      <= Idle;
            resp_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= Idle;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dmi_req_o.addr = addr_q;
    dmi_req_o.op   = DTM_NOP;
    dmi_req_o.data = '0;
    if (state_q == Read) begin
      dmi_req_o.op = DTM_READ;
    end else if (state_q == Write) begin
      dmi_req_o.op   = DTM_WRITE;
      dmi_req_o.data = data_q;
    end
  end

  assign capture_o        = {addr_q, data_q, (state_q != Idle) ? DTM_BUSY : error_q};
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmistat_o        = error_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Directed bench for dmi_initiator: expected requests and capture words are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_dmi_initiator;
  import dm::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        update_i = 1'b0;
  logic [40:0] scan_i = '0;
  logic        capture_i = 1'b0;
  logic [40:0] capture_o;
  logic        dmireset_i = 1'b0;
  logic        dmihardreset_i = 1'b0;
  logic        dmi_req_valid_o;
  dmi_req_t    dmi_req_o;
  logic        dmi_req_ready_i = 1'b0;
  logic        dmi_resp_valid_i = 1'b0;
  dmi_resp_t   dmi_resp_i = '0;
  logic        dmi_resp_ready_o;
  dtm_op_status_e dmistat_o;
  dmi_state_e  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  logic [40:0] exp_req_q[$];
  logic [40:0] exp_cap_q[$];

  dmi_initiator #(.DmiAddrWidth(7)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .update_i         (update_i),
    .scan_i           (scan_i),
    .capture_i        (capture_i),
    .capture_o        (capture_o),
    .dmireset_i       (dmireset_i),
    .dmihardreset_i   (dmihardreset_i),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmistat_o        (dmistat_o),
    .state_o          (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op);
    scan_i   = {addr, data, op};
    update_i = 1'b1;
    cyc();
    update_i = 1'b0;
  endtask

  task automatic do_capture(input logic [40:0] exp);
    exp_cap_q.push_back(exp);
    capture_i = 1'b1;
    cyc();
    capture_i = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_i       = '{data: data, resp: resp};
    dmi_resp_valid_i = 1'b1;
    cyc();
    dmi_resp_valid_i = 1'b0;
  endtask

  task automatic pulse_dmireset();
    dmireset_i = 1'b1;
    cyc();
    dmireset_i = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (dmi_req_valid_o && dmi_req_ready_i) begin
      hs_count++;
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", {23'h0, dmi_req_o}, 64'h1_0000_0000_0000);
      end else begin
        check("req_handshake", {23'h0, dmi_req_o}, {23'h0, exp_req_q.pop_front()});
      end
    end
    if (capture_i) begin
      if (exp_cap_q.size() == 0) begin
        check("unexpected_capture", {23'h0, capture_o}, 64'h1_0000_0000_0000);
      end else begin
        check("capture_word", {23'h0, capture_o}, {23'h0, exp_cap_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_before;

    // reset state
    repeat (3) cyc();
    check("rst_valid", dmi_req_valid_o, 0);
    check("rst_resp_ready", dmi_resp_ready_o, 0);
    check("rst_dmistat", dmistat_o, 0);
    check("rst_capture", capture_o, 0);
    rst_i = 1'b0;
    cyc();
    check("idle_state", state_o, 0);
    check("idle_capture", capture_o, 0);

    // read with immediate ready, response after a few cycles
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h11, 2'h1, 32'h0});
    do_update(7'h11, 32'h0, 2'h1);
    check("read_valid_n1", dmi_req_valid_o, 1);
    check("read_req_word", dmi_req_o, {7'h11, 2'h1, 32'h0});
    cyc();
    dmi_req_ready_i = 1'b0;
    check("read_wait_state", state_o, 2);
    check("read_resp_ready", dmi_resp_ready_o, 1);
    check("read_valid_drop", dmi_req_valid_o, 0);
    cyc();
    cyc();
    do_resp(32'hDEADBEEF, 2'h0);
    check("read_back_idle", state_o, 0);
    check("read_resp_ready_low", dmi_resp_ready_o, 0);
    // stray response activity in Idle must not disturb anything
    do_resp(32'hFFFFFFFF, 2'h2);
    check("stray_resp_dmistat", dmistat_o, 0);
    do_capture({7'h11, 32'hDEADBEEF, 2'h0});

    // write with ready held low for 4 cycles
    hs_before = hs_count;
    exp_req_q.push_back({7'h04, 2'h2, 32'h12345678});
    do_update(7'h04, 32'h12345678, 2'h2);
    for (int i = 0; i < 4; i++) begin
      check("write_hold_valid", dmi_req_valid_o, 1);
      check("write_hold_req", dmi_req_o, {7'h04, 2'h2, 32'h12345678});
      cyc();
    end
    dmi_req_ready_i = 1'b1;
    cyc();
    dmi_req_ready_i = 1'b0;
    check("write_one_handshake", hs_count - hs_before, 1);
    check("write_wait_state", state_o, 4);
    do_resp(32'hCAFEF00D, 2'h0);
    check("write_dmistat", dmistat_o, 0);
    do_capture({7'h04, 32'h12345678, 2'h0});

    // busy: capture during WaitRead, update ignored until dmireset
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h22, 2'h1, 32'h0});
    do_update(7'h22, 32'h0, 2'h1);
    cyc();
    dmi_req_ready_i = 1'b0;
    do_capture({7'h22, 32'h12345678, 2'h3});
    check("busy_dmistat", dmistat_o, 3);
    do_resp(32'h0BADCAFE, 2'h0);
    do_update(7'h05, 32'hA5A5A5A5, 2'h2);
    for (int i = 0; i < 2; i++) begin
      check("busy_no_req", dmi_req_valid_o, 0);
      cyc();
    end
    do_capture({7'h22, 32'h0BADCAFE, 2'h3});
    pulse_dmireset();
    check("busy_cleared", dmistat_o, 0);
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h05, 2'h2, 32'hA5A5A5A5});
    do_update(7'h05, 32'hA5A5A5A5, 2'h2);
    check("busy_after_reset_valid", dmi_req_valid_o, 1);
    cyc();
    dmi_req_ready_i = 1'b0;
    do_resp(32'h0, 2'h0);

    // error response on a write blocks the next read
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h06, 2'h2, 32'h0000FFFF});
    do_update(7'h06, 32'h0000FFFF, 2'h2);
    cyc();
    dmi_req_ready_i = 1'b0;
    do_resp(32'h12121212, 2'h2);
    check("err_dmistat", dmistat_o, 2);
    do_update(7'h33, 32'h0, 2'h1);
    for (int i = 0; i < 3; i++) begin
      check("err_no_req", dmi_req_valid_o, 0);
      cyc();
    end
    do_capture({7'h06, 32'h0000FFFF, 2'h2});
    pulse_dmireset();
    check("err_cleared", dmistat_o, 0);

    // simultaneous update and capture: capture shows pre-update values
    dmi_req_ready_i = 1'b1;
    exp_cap_q.push_back({7'h06, 32'h0000FFFF, 2'h0});
    exp_req_q.push_back({7'h44, 2'h1, 32'h0});
    scan_i    = {7'h44, 32'h0, 2'h1};
    update_i  = 1'b1;
    capture_i = 1'b1;
    cyc();
    update_i  = 1'b0;
    capture_i = 1'b0;
    check("simul_valid", dmi_req_valid_o, 1);
    check("simul_dmistat", dmistat_o, 0);
    cyc();
    dmi_req_ready_i = 1'b0;
    do_resp(32'h44444444, 2'h0);

    // dmireset beats same-cycle busy, then hardreset aborts a pending read
    do_update(7'h7F, 32'h0, 2'h1);
    check("hr_valid_before", dmi_req_valid_o, 1);
    exp_cap_q.push_back({7'h7F, 32'h44444444, 2'h3});
    capture_i  = 1'b1;
    dmireset_i = 1'b1;
    cyc();
    capture_i  = 1'b0;
    dmireset_i = 1'b0;
    check("dmireset_priority", dmistat_o, 0);
    dmihardreset_i = 1'b1;
    cyc();
    dmihardreset_i = 1'b0;
    check("hr_valid_drop", dmi_req_valid_o, 0);
    check("hr_capture", capture_o, 0);
    check("hr_state", state_o, 0);

    // async reset in the middle of WaitWrite
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h09, 2'h2, 32'h00000099});
    do_update(7'h09, 32'h00000099, 2'h2);
    cyc();
    dmi_req_ready_i = 1'b0;
    check("ar_wait_state", state_o, 4);
    do_capture({7'h09, 32'h00000099, 2'h3});
    check("ar_busy_before", dmistat_o, 3);
    #3;
    rst_i = 1'b1;
    #1;
    check("ar_valid", dmi_req_valid_o, 0);
    check("ar_resp_ready", dmi_resp_ready_o, 0);
    check("ar_dmistat", dmistat_o, 0);
    check("ar_capture", capture_o, 0);
    check("ar_state", state_o, 0);
    cyc();
    rst_i = 1'b0;
    cyc();

    // resume without any extra update after reset release
    dmi_req_ready_i = 1'b1;
    exp_req_q.push_back({7'h01, 2'h1, 32'h0});
    do_update(7'h01, 32'h0, 2'h1);
    cyc();
    dmi_req_ready_i = 1'b0;
    do_resp(32'h600DF00D, 2'h0);
    do_capture({7'h01, 32'h600DF00D, 2'h0});

    cyc();
    check("req_queue_drained", exp_req_q.size(), 0);
    check("cap_queue_drained", exp_cap_q.size(), 0);
    check("total_handshakes", hs_count, 8);
    summary();
    $finish;
  end

endmodule
